// File: rtl/starflux_pkg.sv
// starflux_pkg: screen geometry, colour codes and sequencer states for the game controller
package starflux_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_PLAYER = 3'b010;
  localparam logic [2:0] COL_ENEMY = 3'b100;
  localparam logic [2:0] COL_SHOT = 3'b111;
  typedef enum logic [2:0] {IDLE, WAIT, SHIP, GRID, DRAW} state_t;
endpackage

// File: rtl/frame_sequencer_pixel_compositor.sv
// pixel_compositor: priority colour select of player, enemy and shot grid for one pixel
module pixel_compositor
  import starflux_pkg::*;
#(
  parameter int SHIP_W = 8,
  parameter int SHIP_Y = 112,
  parameter int ENEMY_H = 8
) (
  input  logic [7:0] rd_x,
  input  logic [6:0] rd_y,
  input  logic [7:0] user_x,
  input  logic [7:0] enemy_x,
  input  logic       grid_bit,
  output logic [2:0] colour
);
  logic [8:0] px, ux, ex;
  logic player, enemy;
  // 9-bit sums keep sprites near the right edge clipped instead of wrapping
  always_comb begin
    px = {1'b0, rd_x};
    ux = {1'b0, user_x};
    ex = {1'b0, enemy_x};
    player = rd_y >= 7'(SHIP_Y) && px >= ux && px < ux + 9'(SHIP_W);
    enemy = rd_y < 7'(ENEMY_H) && px >= ex && px < ex + 9'(SHIP_W);
    colour = player ? COL_PLAYER : enemy ? COL_ENEMY : grid_bit ? COL_SHOT : COL_BLACK;
  end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-tick ship/grid update pulses followed by a full-screen VGA plot sweep
module frame_sequencer
  import starflux_pkg::*;
#(
  parameter int TICK_CYCLES = 833333,
  parameter int SHIP_W = 8,
  parameter int SHIP_Y = 112,
  parameter int ENEMY_H = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] user_x,
  input  logic [7:0] enemy_x,
  input  logic       grid_bit,
  output logic       shipUpdateEn,
  output logic       gridUpdateEn,
  output logic [7:0] rd_x,
  output logic [6:0] rd_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       overrun
);
  localparam int CW = $clog2(TICK_CYCLES);
  state_t state;
  logic [CW-1:0] count;
  logic pending, tick, last_x, last_y;
  logic [2:0] pixel;
  assign tick = count == CW'(TICK_CYCLES - 1);
  assign last_x = rd_x == 8'(SCREEN_W - 1);
  assign last_y = rd_y == 7'(SCREEN_H - 1);
  pixel_compositor #(.SHIP_W(SHIP_W), .SHIP_Y(SHIP_Y), .ENEMY_H(ENEMY_H)) u_comp (
    .rd_x(rd_x),
    .rd_y(rd_y),
    .user_x(user_x),
    .enemy_x(enemy_x),
    .grid_bit(grid_bit),
    .colour(pixel)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      pending <= 1'b0;
      shipUpdateEn <= 1'b0;
      gridUpdateEn <= 1'b0;
      rd_x <= '0;
      rd_y <= '0;
      x <= '0;
      y <= '0;
      colour <= '0;
      plot <= 1'b0;
      overrun <= 1'b0;
    end else begin
      count <= (state == IDLE || tick) ? '0 : count + 1'b1;
      shipUpdateEn <= 1'b0;
      gridUpdateEn <= 1'b0;
      plot <= 1'b0;
      if (tick && state inside {SHIP, GRID, DRAW}) begin
        pending <= 1'b1;
        overrun <= 1'b1;
      end
      case (state)
        IDLE: if (start) state <= WAIT;
        WAIT:
          if ((tick || pending) && !pause) begin
            state <= SHIP;
            shipUpdateEn <= 1'b1;
            pending <= 1'b0;
          end else if (tick) pending <= 1'b1;
        SHIP: begin
          state <= GRID;
          gridUpdateEn <= 1'b1;
        end
        GRID: state <= DRAW;
        DRAW: begin
          plot <= 1'b1;
          x <= rd_x;
          y <= rd_y;
          colour <= pixel;
          rd_x <= last_x ? '0 : rd_x + 1'b1;
          if (last_x) rd_y <= last_y ? '0 : rd_y + 1'b1;
          if (last_x && last_y) state <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: two sequencers (slow and fast tick) checked every cycle against a timeline model
module tb_frame_sequencer;
  localparam int NPIX = 160 * 120;
  localparam int TA = 20000;
  localparam int TB = 100;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rst = 2'b11, start = 2'b00, pause = 2'b00;
  logic [1:0] gbit, ship, gen, plot, ovr;
  logic [1:0][7:0] ux, ex, rx, xo;
  logic [1:0][6:0] ry, yo;
  logic [1:0][2:0] col;
  bit ga[120][160];
  bit gb[120][160];
  assign gbit[0] = (ry[0] < 7'd120 && rx[0] < 8'd160) ? ga[ry[0]][rx[0]] : 1'b0;
  assign gbit[1] = (ry[1] < 7'd120 && rx[1] < 8'd160) ? gb[ry[1]][rx[1]] : 1'b0;
  frame_sequencer #(.TICK_CYCLES(TA)) dut_a (
    .clk(clk), .reset(rst[0]), .start(start[0]), .pause(pause[0]),
    .user_x(ux[0]), .enemy_x(ex[0]), .grid_bit(gbit[0]),
    .shipUpdateEn(ship[0]), .gridUpdateEn(gen[0]), .rd_x(rx[0]), .rd_y(ry[0]),
    .x(xo[0]), .y(yo[0]), .colour(col[0]), .plot(plot[0]), .overrun(ovr[0])
  );
  frame_sequencer #(.TICK_CYCLES(TB)) dut_b (
    .clk(clk), .reset(rst[1]), .start(start[1]), .pause(pause[1]),
    .user_x(ux[1]), .enemy_x(ex[1]), .grid_bit(gbit[1]),
    .shipUpdateEn(ship[1]), .gridUpdateEn(gen[1]), .rd_x(rx[1]), .rd_y(ry[1]),
    .x(xo[1]), .y(yo[1]), .colour(col[1]), .plot(plot[1]), .overrun(ovr[1])
  );
  int errors = 0, checks = 0, cyc = 0;
  int tper[2] = '{TA, TB};
  // model: m_f is the cycle a frame's SHIP pulse appears; DRAW covers m_f+2 .. m_f+NPIX+1
  int m_t[2], m_f[2];
  bit m_idle[2], m_pend[2], m_ovr[2];
  logic [1:0] e_ship, e_grid, e_plot, e_ovr;
  int e_rx[2], e_ry[2], e_x[2], e_y[2];
  logic [2:0] e_col[2];
  int plots[2], ship_n[2];
  int ship_at[2][8];
  function automatic logic [2:0] colour_of(int px, int py, int u, int e, bit g);
    if (py >= 112 && px >= u && px < u + 8) return 3'b010;
    if (py < 8 && px >= e && px < e + 8) return 3'b100;
    return g ? 3'b111 : 3'b000;
  endfunction
  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  task automatic step(int i, int k);
    int p;
    bit tick, busy, g;
    if (k >= m_f[i] + 2 && k <= m_f[i] + NPIX + 1) begin
      p = k - m_f[i] - 2;
      e_x[i] = p % 160;
      e_y[i] = p / 160;
      g = (i == 0) ? ga[e_y[i]][e_x[i]] : gb[e_y[i]][e_x[i]];
      e_col[i] = colour_of(e_x[i], e_y[i], int'(ux[i]), int'(ex[i]), g);
      e_plot[i] = 1'b1;
    end else e_plot[i] = 1'b0;
    if (rst[i]) begin
      m_idle[i] = 1; m_f[i] = -4 * NPIX; m_pend[i] = 0; m_ovr[i] = 0; m_t[i] = 0;
      e_plot[i] = 1'b0;
    end else if (m_idle[i]) begin
      if (start[i]) begin m_idle[i] = 0; m_t[i] = 0; end
    end else begin
      tick = (m_t[i] % tper[i]) == tper[i] - 1;
      m_t[i]++;
      busy = k >= m_f[i] && k <= m_f[i] + NPIX + 1;
      if (busy) begin
        if (tick) begin m_pend[i] = 1; m_ovr[i] = 1; end
      end else if ((tick || m_pend[i]) && !pause[i]) begin
        m_f[i] = k + 1;
        m_pend[i] = 0;
      end else if (tick) m_pend[i] = 1;
    end
    e_ship[i] = (k + 1 == m_f[i]);
    e_grid[i] = (k + 1 == m_f[i] + 1);
    if (k + 1 >= m_f[i] + 2 && k + 1 <= m_f[i] + NPIX + 1) begin
      p = k + 1 - m_f[i] - 2;
      e_rx[i] = p % 160;
      e_ry[i] = p / 160;
    end else begin
      e_rx[i] = 0;
      e_ry[i] = 0;
    end
    e_ovr[i] = m_ovr[i];
  endtask
  initial begin
    m_f = '{-4 * NPIX, -4 * NPIX};
    m_idle = '{1, 1};
    forever begin
      @(posedge clk);
      step(0, cyc);
      step(1, cyc);
      cyc++;
    end
  end
  // literal colour pins: -1 none, -2 anything but player
  function automatic int pin(int i, int px, int py, int u);
    if (i == 0) begin
      if ((px == 40 && py == 112) || (px == 47 && py == 119)) return 2;
      if ((px == 48 && py == 112) || (px == 100 && py == 8)) return 0;
      if (px == 100 && py == 0) return 4;
      if (px == 5 && py == 50) return 7;
      return -1;
    end
    if (px == 5 && py == 50) return 7;
    if (u == 3 && px == 5 && py == 115) return 2;
    if (u == 156 && ((px == 156 && py == 112) || (px == 159 && py == 119))) return 2;
    if (u == 156 && py >= 112 && px < 4) return -2;
    return -1;
  endfunction
  initial begin
    logic [36:0] a, e;
    int w;
    forever begin
      @(negedge clk);
      if (cyc >= 1)
        for (int i = 0; i < 2; i++) begin
          a = {ship[i], gen[i], plot[i], ovr[i], rx[i], ry[i],
               e_plot[i] ? {xo[i], yo[i], col[i]} : 18'd0};
          e = {e_ship[i], e_grid[i], e_plot[i], e_ovr[i], 8'(e_rx[i]), 7'(e_ry[i]),
               e_plot[i] ? {8'(e_x[i]), 7'(e_y[i]), e_col[i]} : 18'd0};
          checks++;
          if (a !== e) begin
            errors++;
            $display("FAIL cycle %0d dut%0d outputs got=%h want=%h", cyc, i, a, e);
          end
          if (ship[i] === 1'b1) begin
            if (ship_n[i] < 8) ship_at[i][ship_n[i]] = cyc;
            ship_n[i]++;
          end
          if (plot[i] === 1'b1) begin
            plots[i]++;
            w = pin(i, int'(xo[i]), int'(yo[i]), int'(ux[i]));
            if (w == -2) chk($sformatf("dut%0d pin (%0d,%0d) not player", i, xo[i], yo[i]),
                             int'(col[i] == 3'b010), 0);
            else if (w >= 0) chk($sformatf("dut%0d pin (%0d,%0d) colour", i, xo[i], yo[i]),
                                 int'(col[i]), w);
          end
        end
    end
  end
  initial begin
    int sa, sb, r, t;
    ux[0] = 8'd40; ex[0] = 8'd100;
    ux[1] = 8'd3; ex[1] = 8'($urandom_range(0, 159));
    ga[50][5] = 1'b1;
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++) gb[yy][xx] = ($urandom_range(0, 7) == 0);
    gb[50][5] = 1'b1;
    gb[115][5] = 1'b1;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 rst[0] = 1'b0;
        @(posedge clk);
        #1 start[0] = 1'b1; sa = cyc;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (TA + NPIX + 100) @(posedge clk);
        #1;
        chk("slow ship latency", ship_at[0][0] - sa, TA + 1);
        chk("slow ship count", ship_n[0], 1);
        chk("slow plot count", plots[0], NPIX);
        chk("slow overrun", int'(ovr[0]), 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 rst[1] = 1'b0;
        @(posedge clk);
        #1 start[1] = 1'b1; sb = cyc;
        @(posedge clk);
        #1 start[1] = 1'b0;
        repeat (10000) @(posedge clk);
        #1 chk("fast overrun in draw", int'(ovr[1]), 1);
        chk("fast first ship", ship_at[1][0] - sb, TB + 1);
        pause[1] = 1'b1;
        repeat (9300 + $urandom_range(250, 350)) @(posedge clk);
        #1 pause[1] = 1'b0;
        r = cyc;
        ux[1] = 8'($urandom_range(0, 152));
        ex[1] = 8'($urandom_range(0, 159));
        repeat (5003) @(posedge clk);
        #1 rst[1] = 1'b1;
        chk("paused ships collapse", ship_n[1], 2);
        chk("ship after release", ship_at[1][1] - r, 1);
        @(posedge clk);
        #1;
        chk("plot after reset", int'(plot[1]), 0);
        chk("overrun after reset", int'(ovr[1]), 0);
        rst[1] = 1'b0;
        repeat (50) @(posedge clk);
        #1 ux[1] = 8'd156;
        start[1] = 1'b1; t = cyc;
        @(posedge clk);
        #1 start[1] = 1'b0;
        repeat (19400) @(posedge clk);
        #1;
        chk("fast ship count", ship_n[1], 4);
        chk("restart ship latency", ship_at[1][2] - t, TB + 1);
        chk("back-to-back frame", ship_at[1][3] - ship_at[1][2], NPIX + 3);
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
